mxint8_block_quantizer: RTL and testbench

//  Streaming packer that converts BLOCK_SIZE float32 scalars into one MXINT8 block:
//  a shared E8M0 scale plus BLOCK_SIZE int8 elements. Sits directly upstream of

---
 rtl/mxint8_block_quantizer_pkg.sv | 32 +++
 rtl/mxint8_block_quantizer_if.sv | 34 +++
 rtl/mxint8_element_quantize.sv | 52 +++++
 rtl/mxint8_block_quantizer.sv | 127 ++++++++++++
 tb/tb_mxint8_block_quantizer.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/mxint8_block_quantizer_pkg.sv
// rtl/mxint8_block_quantizer_pkg.sv - shared constants, FSM states and float32 field helpers
//
// Purpose: MXINT8 format constants (element magnitude limit, fraction bits,
// NaN scale code), the block quantizer FSM state type and float32 field
// extraction helpers used by the quantizer and its element sub-module.
// Ports: none (package).
package mxint8_block_quantizer_pkg;

  localparam logic [7:0] MXINT8_ELEM_MAX  = 8'd127;
  localparam int         MXINT8_FRAC_BITS = 6;
  localparam logic [7:0] SCALE_NAN        = 8'hFF;
  localparam int         FLOAT32_MANT_W   = 23;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_QUANT,
    ST_OUTPUT
  } state_e;

  function automatic logic float32_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [7:0] float32_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [22:0] float32_mant(input logic [31:0] f);
    return f[22:0];
  endfunction

endpackage

// File: rtl/mxint8_block_quantizer_if.sv
// rtl/mxint8_block_quantizer_if.sv - float32 input stream and MXINT8 block output bundle
//
// Purpose: groups the element input handshake and the block output handshake.
// Signals:
//   i_valid / o_ready / i_float32         element input stream
//   o_valid / i_ready                     block output handshake
//   o_scale                               shared E8M0 scale (0xFF = NaN block)
//   o_mxint8_elements[BLOCK_SIZE]         int8 two's-complement elements
//   o_saturated                           some element clamped to +/-127
// Modports: master = producer/consumer side, slave = quantizer side.
interface mxint8_block_quantizer_if #(
  parameter int BLOCK_SIZE = 32
);

  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_float32;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_scale;
  logic [7:0]  o_mxint8_elements [BLOCK_SIZE];
  logic        o_saturated;

  modport master (
    output i_valid, i_float32, i_ready,
    input  o_ready, o_valid, o_scale, o_mxint8_elements, o_saturated
  );

  modport slave (
    input  i_valid, i_float32, i_ready,
    output o_ready, o_valid, o_scale, o_mxint8_elements, o_saturated
  );

endinterface

// File: rtl/mxint8_element_quantize.sv
// rtl/mxint8_element_quantize.sv - combinational float32 to int8 conversion against a shared scale
//
// Purpose: converts one float32 into an MXINT8 element relative to scale S,
// element = round_half_away(value / 2^(S-127-6)), clamped to +/-127.
// Ports:
//   float32    in   32  IEEE-754 single input
//   scale      in   8   shared E8M0 scale of the block (0xFF = NaN block)
//   element    out  8   two's-complement element
//   saturated  out  1   magnitude was clamped to 127
module mxint8_element_quantize
  import mxint8_block_quantizer_pkg::*;
(
  input  logic [31:0] float32,
  input  logic [7:0]  scale,
  output logic [7:0]  element,
  output logic        saturated
);

  logic [7:0]  exp_field;
  logic [7:0]  diff;
  logic [23:0] sig;
  logic [4:0]  shamt;
  logic [7:0]  shifted;
  logic        round_bit;
  logic [8:0]  mag;
  logic [7:0]  mag_sat;

  always_comb begin
    element   = '0;
    saturated = 1'b0;
    mag_sat   = '0;
    exp_field = float32_exp(float32);
    // Scale is the block maximum, so diff never goes negative for a valid block.
    diff      = scale - exp_field;
    sig       = {1'b1, float32_mant(float32)};
    // Leading one lands at bit 6 of the integer result when diff == 0.
    shamt     = 5'(FLOAT32_MANT_W - MXINT8_FRAC_BITS) + {2'b00, diff[2:0]};
    shifted   = 8'(sig >> shamt);
    round_bit = sig[shamt - 5'd1];
    mag       = {1'b0, shifted} + {8'b0, round_bit};
    if (exp_field != 8'h00 && exp_field != 8'hFF && scale != SCALE_NAN && diff < 8'd8) begin
      if (mag > {1'b0, MXINT8_ELEM_MAX}) begin
        mag_sat   = MXINT8_ELEM_MAX;
        saturated = 1'b1;
      end else begin
        mag_sat = mag[7:0];
      end
      element = float32_sign(float32) ? -mag_sat : mag_sat;
    end
  end

endmodule

// File: rtl/mxint8_block_quantizer.sv
// rtl/mxint8_block_quantizer.sv - streams BLOCK_SIZE float32 scalars into one MXINT8 block
//
// Purpose: collects BLOCK_SIZE float32 elements, derives the shared scale
// (max biased exponent, 0xFF if any Inf/NaN), quantizes one element per
// cycle, then presents the block until the consumer takes it.
// Ports:
//   i_clk    in  1   clock, rising edge
//   i_rst_n  in  1   asynchronous active-low reset
//   bus      slave modport of mxint8_block_quantizer_if (element input
//            stream, block output handshake, scale, elements, saturation)
module mxint8_block_quantizer
  import mxint8_block_quantizer_pkg::*;
#(
  parameter int BLOCK_SIZE = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  mxint8_block_quantizer_if.slave  bus
);

  localparam int                IDX_W    = $clog2(BLOCK_SIZE);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BLOCK_SIZE - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       max_exp_q;
  logic             nan_q;
  logic [7:0]       scale_q;
  logic             sat_q;
  logic [31:0]      buffer_q [BLOCK_SIZE];
  logic [7:0]       elem_q   [BLOCK_SIZE];

  logic             ready_c;
  logic             valid_c;
  logic             accept;
  logic             last_idx;
  logic [7:0]       in_exp;
  logic [7:0]       max_exp_next;
  logic             nan_next;
  logic [7:0]       q_elem;
  logic             q_sat;

  assign accept       = bus.i_valid && ready_c;
  assign last_idx     = (idx_q == IDX_LAST);
  assign in_exp       = float32_exp(bus.i_float32);
  assign max_exp_next = (accept && in_exp > max_exp_q) ? in_exp : max_exp_q;
  assign nan_next     = nan_q | (accept && in_exp == 8'hFF);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_COLLECT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    valid_c = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        ready_c = 1'b1;
        if (accept && last_idx) state_d = ST_QUANT;
      end
      ST_QUANT: begin
        if (last_idx) state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        valid_c = 1'b1;
        if (bus.i_ready) state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // Input buffer needs no reset: every entry is rewritten before it is read.
  always_ff @(posedge i_clk) begin
    if (accept) buffer_q[idx_q] <= bus.i_float32;
  end

  mxint8_element_quantize u_quant (
    .float32   (buffer_q[idx_q]),
    .scale     (scale_q),
    .element   (q_elem),
    .saturated (q_sat)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q     <= '0;
      max_exp_q <= '0;
      nan_q     <= 1'b0;
      scale_q   <= '0;
      sat_q     <= 1'b0;
      for (int k = 0; k < BLOCK_SIZE; k++) elem_q[k] <= '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (accept) begin
            // Power-of-two block size: the index wraps to 0 after the last element.
            idx_q <= idx_q + 1'b1;
            if (last_idx) begin
              scale_q   <= nan_next ? SCALE_NAN : max_exp_next;
              sat_q     <= 1'b0;
              max_exp_q <= '0;
              nan_q     <= 1'b0;
            end else begin
              max_exp_q <= max_exp_next;
              nan_q     <= nan_next;
            end
          end
        end
        ST_QUANT: begin
          elem_q[idx_q] <= q_elem;
          sat_q         <= sat_q | q_sat;
          idx_q         <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready           = ready_c;
  assign bus.o_valid           = valid_c;
  assign bus.o_scale           = scale_q;
  assign bus.o_mxint8_elements = elem_q;
  assign bus.o_saturated       = sat_q;

endmodule

// File: tb/tb_mxint8_block_quantizer.sv
// tb/tb_mxint8_block_quantizer.sv - directed table-driven bench for mxint8_block_quantizer
module tb_mxint8_block_quantizer;

  localparam int BS = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mxint8_block_quantizer_if #(.BLOCK_SIZE(BS)) bus ();

  mxint8_block_quantizer #(.BLOCK_SIZE(BS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] v0, v1, v2, fill;
    int          sp_idx;
    logic [31:0] sp_val;
    logic [7:0]  x_scale, x0, x1, x2, x_rest;
    logic        x_sat;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] elem_in(input vec_t v, input int k);
    if (k == v.sp_idx) return v.sp_val;
    case (k)
      0: return v.v0;
      1: return v.v1;
      2: return v.v2;
      default: return v.fill;
    endcase
  endfunction

  function automatic logic [7:0] elem_exp(input vec_t v, input int k);
    case (k)
      0: return v.x0;
      1: return v.x1;
      2: return v.x2;
      default: return v.x_rest;
    endcase
  endfunction

  task automatic send_block(input vec_t v);
    for (int k = 0; k < BS; k++) begin
      @(negedge clk);
      bus.i_valid   = 1'b1;
      bus.i_float32 = elem_in(v, k);
    end
    @(negedge clk);
    bus.i_valid   = 1'b0;
    bus.i_float32 = 32'hDEAD_BEEF;
  endtask

  task automatic run_vector(input vec_t v, input bit stall);
    int         n;
    logic [7:0] hold_scale;
    logic [7:0] hold_e0;
    send_block(v);
    n = 0;
    while (!bus.o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_valid) begin
      check({v.name, " timeout"}, 32'd0, 32'd1);
      return;
    end
    check({v.name, " latency"}, 32'(n + 1), 32'(BS + 1));
    check({v.name, " o_ready in OUTPUT"}, 32'(bus.o_ready), 32'd0);
    check({v.name, " scale"}, 32'(bus.o_scale), 32'(v.x_scale));
    check({v.name, " saturated"}, 32'(bus.o_saturated), 32'(v.x_sat));
    for (int k = 0; k < BS; k++)
      check($sformatf("%s elem%0d", v.name, k), 32'(bus.o_mxint8_elements[k]), 32'(elem_exp(v, k)));
    if (stall) begin
      hold_scale = v.x_scale;
      hold_e0    = v.x0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check($sformatf("stall%0d o_valid", c), 32'(bus.o_valid), 32'd1);
        check($sformatf("stall%0d o_ready", c), 32'(bus.o_ready), 32'd0);
        check($sformatf("stall%0d scale", c), 32'(bus.o_scale), 32'(hold_scale));
        check($sformatf("stall%0d elem0", c), 32'(bus.o_mxint8_elements[0]), 32'(hold_e0));
      end
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    check({v.name, " o_valid after handshake"}, 32'(bus.o_valid), 32'd0);
    check({v.name, " o_ready after handshake"}, 32'(bus.o_ready), 32'd1);
  endtask

  initial begin
    int nz;
    vecs[0] = '{"ones",    32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, -1, 32'h0,
                8'h7F, 8'h40, 8'h40, 8'h40, 8'h40, 1'b0};
    vecs[1] = '{"mixed",   32'h4000_0000, 32'h3F80_0000, 32'hBF00_0000, 32'h0000_0000, -1, 32'h0,
                8'h80, 8'h40, 8'h20, 8'hF0, 8'h00, 1'b0};
    vecs[2] = '{"sat_pos", 32'h3FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, -1, 32'h0,
                8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{"nan",     32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 5, 32'h7FC0_0000,
                8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{"sat_neg", 32'hC2FF_0000, 32'h3F80_0000, 32'h3E00_0000, 32'h8000_0000, -1, 32'h0,
                8'h85, 8'h81, 8'h01, 8'h00, 8'h00, 1'b1};
    vecs[5] = '{"round_d7", 32'h4000_0000, 32'h3C80_0000, 32'h3C00_0000, 32'h0000_0001, -1, 32'h0,
                8'h80, 8'h40, 8'h01, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{"zeros",   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, -1, 32'h0,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

    rst_n         = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_ready   = 1'b0;
    bus.i_float32 = '0;
    repeat (2) @(negedge clk);
    check("reset o_valid", 32'(bus.o_valid), 32'd0);
    check("reset o_ready", 32'(bus.o_ready), 32'd1);
    check("reset scale", 32'(bus.o_scale), 32'd0);
    check("reset saturated", 32'(bus.o_saturated), 32'd0);
    nz = 0;
    for (int k = 0; k < BS; k++) if (bus.o_mxint8_elements[k] != 8'h00) nz++;
    check("reset nonzero elements", 32'(nz), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vector(vecs[i], i == 1);

    // Reset while quantizing a block of ones: outputs clear at once, block is dropped.
    run_vector(vecs[0], 1'b0);
    send_block(vecs[0]);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset o_valid", 32'(bus.o_valid), 32'd0);
    check("midreset scale", 32'(bus.o_scale), 32'd0);
    check("midreset saturated", 32'(bus.o_saturated), 32'd0);
    nz = 0;
    for (int k = 0; k < BS; k++) if (bus.o_mxint8_elements[k] != 8'h00) nz++;
    check("midreset nonzero elements", 32'(nz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vector(vecs[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
